cache_arbiter: RTL
==================

# cache_arbiter

- Shares one physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core.
- Grants one requester at a time and forwards the latched address, write data and read/write strobe to memory.
- Returns the memory response and line data to the granted requester only.
- Ties are broken round-robin, so neither cache can starve the other.

## Interface
Parameters:
- ADDR_WIDTH, 16, byte address width
- LINE_WIDTH, 128, cache line width in bits

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- i_read  in  1  I-cache line read request, level, held until i_resp
- i_address  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line returned to I-cache
- i_resp  out  1  one-cycle completion to I-cache
- d_read  in  1  D-cache line read request, level
- d_write  in  1  D-cache line write request, level
- d_address  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  D-cache write line
- d_rdata  out  LINE_WIDTH  line returned to D-cache
- d_resp  out  1  one-cycle completion to D-cache
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_WIDTH  memory address
- pmem_wdata  out  LINE_WIDTH  memory write line
- pmem_rdata  in  LINE_WIDTH  memory read line
- pmem_resp  in  1  memory completion, one cycle

## Operation
- States:
  - IDLE
  - SERVE_I
  - SERVE_D
  - DONE
- Register last_grant: 0 = I, 1 = D.
- IDLE:
  - Only i_read high: latch i_address, go to SERVE_I.
  - Only d_read or d_write high: latch d_address, d_wdata and the op, go to SERVE_D.
  - Both high: grant the requester not equal to last_grant, then update last_grant.
- D request with d_read and d_write both high is a write. d_read is ignored.
- SERVE_x:
  - pmem_read or pmem_write is driven from the latched op.
  - pmem_address and pmem_wdata are driven from the latched registers, stable for the whole transaction.
  - Request inputs are not re-sampled.
- On pmem_resp in SERVE_x:
  - x_resp = 1 in the same cycle (combinational).
  - x_rdata = pmem_rdata.
  - Next state is DONE.
- DONE: all strobes low; go to IDLE next cycle. This is the turnaround that lets the requester drop its level request before re-arbitration.
- Outputs while not granted:
  - Non-granted x_resp is 0.
  - i_rdata and d_rdata are pmem_rdata unconditionally; only resp qualifies them.
- Reset, from any state including mid-transaction:
  - Next state IDLE, last_grant = 0.
  - Latched address/data cleared to 0.
  - pmem_read = pmem_write = 0 from the cycle after the reset edge.
  - A pmem_resp arriving after reset is ignored.
- Strobes are decoded from state and latched op only. No input reaches them combinationally.

## Timing
- Reset values:
  - pmem_read = 0, pmem_write = 0
  - pmem_address = 0, pmem_wdata = 0
  - i_resp = 0, d_resp = 0
- Request seen in IDLE at edge t: pmem strobe high in cycle t+1.
- Memory latency N cycles: x_resp is high in the same cycle as pmem_resp.
- Fixed overhead: 1 grant cycle + 1 DONE cycle.
- Back-to-back requests from the same cache: next grant no earlier than 2 cycles after x_resp.
- pmem_resp outside SERVE_x is ignored.
- A request arriving while another is served waits in its level form. There is no queue.

## Structure
- Shared package lc3b_types:
  - lc3b_word (16-bit)
  - lc3b_line (128-bit)
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D, DONE}
- Sub-module arbiter_control:
  - Holds the FSM and last_grant.
  - Outputs grant select, latch enable and strobe decode.
- Top level holds the address/wdata/op latches and the output muxes.
- Expected size: about 180 RTL lines.

## Test plan
- Lone I read:
  - Stimulus: i_read = 1, i_address = 0x1230; memory responds after 3 cycles with 0xDEAD…BEEF.
  - Response: pmem_read high at t+1; i_resp for 1 cycle carrying that line; d_resp never high; DONE then IDLE.
- Lone D write:
  - Stimulus: d_write = 1, d_address = 0x4000, d_wdata = 0x0123…CDEF.
  - Response: pmem_write high, pmem_address = 0x4000, pmem_wdata stable until pmem_resp; d_resp 1 cycle.
- Simultaneous requests after reset:
  - Stimulus: i_read and d_read held high.
  - Response: D is served first (last_grant reset = I), then I. Three more simultaneous rounds alternate D, I, D.
- Request during service:
  - Stimulus: i_read rises while SERVE_D is waiting on memory.
  - Response: pmem_address stays equal to the D address; I is served after DONE.
- Reset mid-transaction:
  - Stimulus: reset asserted in SERVE_I before pmem_resp; memory then responds one cycle later.
  - Response: strobes low the next cycle, no i_resp, state IDLE.
- Invalid D op:
  - Stimulus: d_read = d_write = 1.
  - Response: pmem_write = 1, pmem_read = 0.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b memory-system types used by the cache arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbitration FSM: picks the next requester round-robin and decodes the memory strobes.
module arbiter_control
    import lc3b_types::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic op_write_i,
    input  logic pmem_resp_i,
    output logic latch_en_o,
    output logic grant_d_o,
    output logic serve_i_o,
    output logic serve_d_o,
    output logic pmem_read_o,
    output logic pmem_write_o
);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        latch_en_o   = 1'b0;
        grant_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req_i || d_req_i) begin
                    // On a tie the cache that did not win last time goes first.
                    grant_d      = (i_req_i && d_req_i) ? ~last_grant_q : d_req_i;
                    latch_en_o   = 1'b1;
                    last_grant_d = grant_d;
                    state_d      = grant_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp_i) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign grant_d_o    = grant_d;
    assign serve_i_o    = (state_q == SERVE_I);
    assign serve_d_o    = (state_q == SERVE_D);
    assign pmem_read_o  = serve_i_o || (serve_d_o && !op_write_i);
    assign pmem_write_o = serve_d_o && op_write_i;

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache of the LC-3b core.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, write_d;
    logic                  latch_en, grant_d, serve_i, serve_d;

    arbiter_control u_control (
        .clk          (clk),
        .reset        (reset),
        .i_req_i      (i_read),
        .d_req_i      (d_read || d_write),
        .op_write_i   (write_q),
        .pmem_resp_i  (pmem_resp),
        .latch_en_o   (latch_en),
        .grant_d_o    (grant_d),
        .serve_i_o    (serve_i),
        .serve_d_o    (serve_d),
        .pmem_read_o  (pmem_read),
        .pmem_write_o (pmem_write)
    );

    // A D request with both strobes high is treated as a write.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        if (latch_en) begin
            addr_d  = grant_d ? d_address : i_address;
            write_d = grant_d && d_write;
            if (grant_d) begin
                wdata_d = d_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_rdata      = pmem_rdata;
    assign d_rdata      = pmem_rdata;
    assign i_resp       = serve_i && pmem_resp;
    assign d_resp       = serve_d && pmem_resp;

endmodule
